// File: rtl/feature_map_serializer.sv
// -----------------------------------------------------------------------------
// feature_map_serializer
//
// Freezes a flattened feature map on `start` and streams it out one element
// per valid/ready transfer, in channel-major, then row, then column order.
// Element n = c*H*W + r*W + k lives at data[n*BITWIDTH +: BITWIDTH].
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   capture `data` and begin streaming (ignored while busy)
//   data        in   flattened map, BITWIDTH*W*H*C bits
//   busy        out  high while a captured map is being streamed
//   m_valid     out  element present on m_data
//   m_ready     in   consumer accepts element
//   m_data      out  current element (0 when m_valid is low)
//   m_row_last  out  element is the last column of its row
//   m_ch_last   out  element is the last of its channel
//   m_last      out  element is the last of the map
//   done        out  one-cycle pulse in the cycle after the final transfer
//
// state  | meaning
// IDLE   | no map held; waiting for start
// STREAM | map captured; presenting element (c,r,k) on the stream port
// -----------------------------------------------------------------------------
module feature_map_serializer #(
    parameter int BITWIDTH    = 8,
    parameter int DATAWIDTH   = 28,
    parameter int DATAHEIGHT  = 28,
    parameter int DATACHANNEL = 3
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  start,
    input  logic [BITWIDTH*DATAWIDTH*DATAHEIGHT*DATACHANNEL-1:0]  data,
    output logic                                                  busy,
    output logic                                                  m_valid,
    input  logic                                                  m_ready,
    output logic [BITWIDTH-1:0]                                   m_data,
    output logic                                                  m_row_last,
    output logic                                                  m_ch_last,
    output logic                                                  m_last,
    output logic                                                  done
);

    localparam int N  = DATAWIDTH * DATAHEIGHT * DATACHANNEL;
    localparam int DW = BITWIDTH * N;

    localparam int KW = (DATAWIDTH   > 1) ? $clog2(DATAWIDTH)   : 1;
    localparam int RW = (DATAHEIGHT  > 1) ? $clog2(DATAHEIGHT)  : 1;
    localparam int CW = (DATACHANNEL > 1) ? $clog2(DATACHANNEL) : 1;
    localparam int NW = (N           > 1) ? $clog2(N)           : 1;

    localparam logic [KW-1:0] K_MAX = KW'(DATAWIDTH - 1);
    localparam logic [RW-1:0] R_MAX = RW'(DATAHEIGHT - 1);
    localparam logic [NW-1:0] N_MAX = NW'(N - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   data_q,  data_d;
    logic [KW-1:0]   k_q,     k_d;
    logic [RW-1:0]   r_q,     r_d;
    logic [CW-1:0]   c_q,     c_d;
    logic [NW-1:0]   n_q,     n_d;
    logic            done_q,  done_d;

    logic            xfer;
    logic            k_wrap;
    logic            r_wrap;
    logic            is_last;

    // Unpacked view of the captured map so the current element is a plain
    // array read indexed by the flat counter.
    logic [BITWIDTH-1:0] elem_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign elem_arr[g] = data_q[g*BITWIDTH +: BITWIDTH];
    end

    // The flat index n runs alongside (c,r,k) so no multiplier is needed to
    // address the element.
    assign k_wrap  = (k_q == K_MAX);
    assign r_wrap  = (r_q == R_MAX);
    assign is_last = (n_q == N_MAX);
    assign xfer    = (state_q == STREAM) && m_ready;

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        k_d     = k_q;
        r_d     = r_q;
        c_d     = c_q;
        n_d     = n_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    data_d  = data;
                    k_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    n_d     = '0;
                end
            end

            STREAM: begin
                if (xfer) begin
                    if (is_last) begin
                        // Leave counters parked at zero for the next map.
                        state_d = IDLE;
                        done_d  = 1'b1;
                        k_d     = '0;
                        r_d     = '0;
                        c_d     = '0;
                        n_d     = '0;
                    end else begin
                        n_d = n_q + NW'(1);
                        if (k_wrap) begin
                            k_d = '0;
                            if (r_wrap) begin
                                r_d = '0;
                                c_d = c_q + CW'(1);
                            end else begin
                                r_d = r_q + RW'(1);
                            end
                        end else begin
                            k_d = k_q + KW'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            k_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            n_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            k_q     <= k_d;
            r_q     <= r_d;
            c_q     <= c_d;
            n_q     <= n_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: everything on the stream port is forced to 0 outside STREAM
    // ------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_row_last = 1'b0;
        m_ch_last  = 1'b0;
        m_last     = 1'b0;

        if (state_q == STREAM) begin
            busy       = 1'b1;
            m_valid    = 1'b1;
            m_data     = elem_arr[n_q];
            m_row_last = k_wrap;
            m_ch_last  = k_wrap && r_wrap;
            m_last     = is_last;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_feature_map_serializer.sv
module tb_feature_map_serializer;

    localparam int BW = 8;
    localparam int W  = 3;
    localparam int H  = 2;
    localparam int C  = 2;
    localparam int N  = W * H * C;
    localparam int DW = BW * N;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] data;
    logic          busy;
    logic          m_valid;
    logic          m_ready;
    logic [BW-1:0] m_data;
    logic          m_row_last;
    logic          m_ch_last;
    logic          m_last;
    logic          done;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] map1;
    logic [DW-1:0] map2;

    feature_map_serializer #(
        .BITWIDTH    (BW),
        .DATAWIDTH   (W),
        .DATAHEIGHT  (H),
        .DATACHANNEL (C)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .data       (data),
        .busy       (busy),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_row_last (m_row_last),
        .m_ch_last  (m_ch_last),
        .m_last     (m_last),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy"},    32'(busy),       32'd0);
        check({tag, " valid"},   32'(m_valid),    32'd0);
        check({tag, " data"},    32'(m_data),     32'd0);
        check({tag, " rowlast"}, 32'(m_row_last), 32'd0);
        check({tag, " chlast"},  32'(m_ch_last),  32'd0);
        check({tag, " last"},    32'(m_last),     32'd0);
    endtask

    // Entered on the negedge right after start was captured. Walks the stream,
    // checking each presented element against base+idx and hand-decoded flags,
    // and ends on the negedge of the done cycle.
    //   bp  : m_ready follows 1,0,0,1,0,0,...
    //   iso : one cycle in, overwrite data with 0xFF and pulse start
    task automatic run_stream(input string tag, input int base, input bit bp, input bit iso);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 200) begin
            m_ready = bp ? (cyc % 3 == 0) : 1'b1;
            if (iso && cyc == 0) begin
                data  = '1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            check({tag, " valid"},   32'(m_valid),    32'd1);
            check({tag, " busy"},    32'(busy),       32'd1);
            check({tag, " data"},    32'(m_data),     32'(base + idx));
            check({tag, " rowlast"}, 32'(m_row_last), 32'((idx % W) == W - 1));
            check({tag, " chlast"},  32'(m_ch_last),  32'((idx % (W * H)) == W * H - 1));
            check({tag, " last"},    32'(m_last),     32'(idx == N - 1));
            check({tag, " nodone"},  32'(done),       32'd0);
            if (m_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        start   = 1'b0;
        m_ready = 1'b1;
        check({tag, " count"}, 32'(idx), N);
        check({tag, " done"},  32'(done), 32'd1);
        check({tag, " busy_at_done"},  32'(busy),    32'd0);
        check({tag, " valid_at_done"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        for (int n = 0; n < N; n++) begin
            map1[n*BW +: BW] = BW'(n + 1);
            map2[n*BW +: BW] = BW'(8'h80 + n);
        end

        // Reset with garbage on the inputs
        rst_n   = 1'b0;
        start   = 1'b1;
        m_ready = 1'b1;
        data    = {$urandom, $urandom, $urandom};
        repeat (3) @(negedge clk);
        check_quiet("rst");
        check("rst done", 32'(done), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel busy", 32'(busy), 32'd0);
        check("rel valid", 32'(m_valid), 32'd0);

        // Basic stream, then back-to-back second map started in the done cycle
        data  = map1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_stream("basic", 1, 1'b0, 1'b0);
        data  = map2;
        start = 1'b1;
        @(negedge clk);
        check("b2b done_pulse", 32'(done), 32'd0);
        start = 1'b0;
        run_stream("b2b", 8'h80, 1'b0, 1'b0);
        @(negedge clk);
        check("b2b done_low", 32'(done), 32'd0);
        check_quiet("idle");

        // Backpressure
        data  = map1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_stream("bp", 1, 1'b1, 1'b0);
        @(negedge clk);

        // Capture isolation with a mid-stream start
        data  = map1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_stream("iso", 1, 1'b0, 1'b1);
        @(negedge clk);
        check("iso no_restart", 32'(m_valid), 32'd0);

        // Reset mid-stream after the 5th transfer
        data    = map1;
        m_ready = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_abort data", 32'(m_data), 32'd6);
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        @(negedge clk);
        check("abort done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort done2", 32'(done), 32'd0);
        check_quiet("post_abort");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_stream("restart", 1, 1'b0, 1'b0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
